// File: rtl/mux_alu_src_b_pipe.sv
// mux_alu_src_b_pipe: ALU operand-B selector feeding a 2-entry FIFO skid buffer.
// Ports:
//   clk_i        rising-edge clock
//   reset_i      synchronous active-high reset
//   b_i          register-file operand B
//   imm_i        raw instruction immediate
//   sel_i        mode select, sampled with in_valid_i
//   in_valid_i   producer offers b_i/imm_i/sel_i
//   in_ready_o   buffer can take an entry (registered state only)
//   operand_o    oldest buffered operand
//   out_valid_o  operand_o is valid
//   out_ready_i  consumer takes operand_o
//   bad_sel_o    sticky: a reserved mode was accepted
module mux_alu_src_b_pipe #(
    parameter int WIDTH  = 32,
    parameter int IMM_W  = 16,
    parameter int SHIFT  = 2,
    parameter int PC_INC = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [IMM_W-1:0] imm_i,
    input  logic [2:0]       sel_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] operand_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             bad_sel_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic [1:0]       cnt_q, cnt_d;
    logic             rd_q, rd_d;
    logic             bad_q, bad_d;
    logic [WIDTH-1:0] sext, res;
    logic             push, pop, wr;

    assign in_ready_o  = cnt_q != 2'd2;
    assign out_valid_o = cnt_q != 2'd0;
    assign operand_o   = mem_q[rd_q];
    assign bad_sel_o   = bad_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    // a push only happens at count 0 or 1, so the tail slot is head xor count
    assign wr          = rd_q ^ cnt_q[0];

    // selection is made at accept time; shifted-out bits in mode 011 are simply truncated
    always_comb begin
        sext  = WIDTH'($signed(imm_i));
        res   = sel_i == 3'd0 ? b_i :
                sel_i == 3'd1 ? WIDTH'(PC_INC) :
                sel_i == 3'd2 ? sext :
                sel_i == 3'd3 ? sext << SHIFT :
                sel_i == 3'd4 ? WIDTH'(imm_i) :
                sel_i == 3'd5 ? WIDTH'(imm_i) << (WIDTH - IMM_W) : '0;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
        rd_d  = rd_q ^ pop;
        bad_d = bad_q | (push && sel_i[2:1] == 2'b11);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q <= '{default: '0};
            cnt_q <= '0;
            rd_q  <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            if (push) mem_q[wr] <= res;
            cnt_q <= cnt_d;
            rd_q  <= rd_d;
            bad_q <= bad_d;
        end
    end
endmodule
